xy_route_ctrl: RTL and testbench
================================

# xy_route_ctrl

Routing and arbitration controller for one 5-port mesh router in the MIMD array. It takes the head-flit destination of each input buffer (Local, N, E, S, W), computes the XY-routed output port, and grants each output port round-robin among its requesters. Grants are held for the whole wormhole packet. It drives the crossbar select lines and the input-buffer pop strobes; the flit datapath and the buffers sit outside this block. The local PE reads its own X/Y from the ID slave; this block uses the same X/Y values as parameters.

## Interface
- X, default 0: column of this router, 2 bits (0..3).
- Y, default 0: row of this router, 2 bits (0..3).
- Port index used on every 5-bit vector: 0 = Local, 1 = N, 2 = E, 3 = S, 4 = W.
- HCLK  in  1  clock; all state on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- in_valid  in  5  input buffer i holds a flit.
- in_head  in  5  flit at buffer i is a head flit.
- in_tail  in  5  flit at buffer i is a tail flit (head and tail may both be set: single-flit packet).
- in_dest  in  20  4 bits per input, {destX[1:0], destY[1:0]}, same packing as Addr_XY; only meaningful when in_head is set.
- in_pop  out  5  buffer i dequeues its flit this cycle.
- out_ready  in  5  downstream link o accepts a flit this cycle.
- out_valid  out  5  flit is presented on output o.
- out_sel  out  15  3 bits per output: crossbar source index for output o.
- err_stray  out  1  one-cycle pulse when a non-head flit is discarded.

## Operation
- Route function, for a head flit at input i:
  - destX > X: output E.
  - destX < X: output W.
  - Otherwise, destY > Y: output N.
  - Otherwise, destY < Y: output S.
  - Otherwise: output Local.
- Input i requests output o only when all hold: in_valid[i], in_head[i], route(i) = o, and input i is not currently owned by any output.
- Per-output state:
  - lock (1 bit), owner (3 bits), rr_ptr (3 bits).
  - IDLE → LOCKED: at least one requester is present. Grant the first requester at or after rr_ptr, searching cyclically through 0..4. Set owner to that input and rr_ptr to owner+1 mod 5.
  - LOCKED → IDLE: a flit with in_tail set transfers.
- out_valid[o] = lock[o] & in_valid[owner[o]]. This is combinational from registered state.
- Transfer on o occurs when out_valid[o] & out_ready[o]. in_pop[owner[o]] asserts in the same cycle.
- out_sel[o] = owner[o]; it holds its last value while IDLE.
- Stray flit: a non-head flit with in_valid set at an input with no owner.
  - That input gets in_pop asserted for that cycle, and err_stray pulses.
  - The flit is never routed.
- Each input is owned by at most one output, which follows from a single route per packet. At most 5 in_pop bits are active per cycle.
- Reset (asynchronous, HRESETn low):
  - All locks cleared; owner = 0; rr_ptr = 0.
  - out_valid = 0, out_sel = 0, in_pop = 0, err_stray = 0.
- Reset asserted mid-packet aborts all locks immediately. Outputs go to their reset values asynchronously.

## Timing
- A head flit visible in cycle n (output idle) is granted at the edge ending cycle n. out_valid rises in cycle n+1. Best-case transfer is cycle n+1, so routing latency is 1 cycle.
- Body flits stream one per cycle while in_valid and out_ready are both high. No bubbles inside a packet.
- A tail transfer in cycle k clears the lock at the edge ending k. Arbitration runs in cycle k+1, and the next packet's out_valid is in cycle k+2: one mandatory idle cycle between packets on the same output.
- Simultaneous requests are resolved by rr_ptr only. Outputs arbitrate independently in the same cycle.
- An owner with in_valid low (buffer empty mid-packet) keeps the lock; out_valid stays low until a flit arrives.
- out_ready low stalls without losing the lock; in_pop stays low.
- A single-flit packet (head & tail) locks for exactly one transfer.

## Test plan
- Reset, X=1, Y=1. Local head, dest {2,1}, single-flit → out_valid[E] in cycle 1, out_sel[E] = 0, in_pop[0] in cycle 1, lock clear by cycle 2.
- X=1, Y=1. Heads at N, S, W all dest {1,1}, each 2 flits, out_ready[L] = 1 → Local grants in order N(1), S(3), W(4). Each packet occupies 2 cycles followed by 1 idle cycle.
- 4-flit packet from E to dest {0,2} with out_ready[W] toggled 1,0,1,0… → all 4 flits in order, in_pop only on ready cycles, no other input granted on W until the tail.
- Concurrent: L → E and N → S packets start in the same cycle → both out_valid rise in cycle 1 with independent sels.
- Body flit (head = 0) at idle input S → in_pop[3] and err_stray pulse in the same cycle; no out_valid.
- HRESETn pulsed low mid-packet → out_valid = 0 immediately. After release, the same input's remaining non-head flits are discarded as strays.

Source files
------------

// File: rtl/xy_route_ctrl.sv
`default_nettype none
// ============================================================================
// xy_route_ctrl : XY route computation and per-output round-robin wormhole
//                 arbitration for one 5-port mesh router (L, N, E, S, W).
// Revision      : 1.0
// ============================================================================
module xy_route_ctrl #(
   parameter logic [1:0] X = 2'd0,
   parameter logic [1:0] Y = 2'd0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [4:0]  in_valid,
   input  logic [4:0]  in_head,
   input  logic [4:0]  in_tail,
   input  logic [19:0] in_dest,
   output logic [4:0]  in_pop,
   input  logic [4:0]  out_ready,
   output logic [4:0]  out_valid,
   output logic [14:0] out_sel,
   output logic        err_stray
);

   localparam logic [2:0] PORT_L = 3'd0;
   localparam logic [2:0] PORT_N = 3'd1;
   localparam logic [2:0] PORT_E = 3'd2;
   localparam logic [2:0] PORT_S = 3'd3;
   localparam logic [2:0] PORT_W = 3'd4;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [14:0] route;
   logic [14:0] owner_flat;
   logic [4:0]  lock;
   logic [4:0]  xfer;
   logic [4:0]  owned;
   logic [4:0]  pop_own;
   logic [4:0]  stray;

   function automatic logic [2:0] wrap5(input logic [3:0] v);
      return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
   endfunction

   for (genvar i = 0; i < 5; i++) begin : g_in
      logic [1:0] dest_x;
      logic [1:0] dest_y;
      assign dest_x = in_dest[4*i+3 -: 2];
      assign dest_y = in_dest[4*i+1 -: 2];
      assign route[3*i +: 3] = (dest_x > X) ? PORT_E :
                               (dest_x < X) ? PORT_W :
                               (dest_y > Y) ? PORT_N :
                               (dest_y < Y) ? PORT_S : PORT_L;
   end

   for (genvar o = 0; o < 5; o++) begin : g_out
      logic [0:0] state;
      logic [0:0] state_nxt;
      logic [2:0] owner;
      logic [2:0] owner_nxt;
      logic [2:0] rr_ptr;
      logic [2:0] rr_nxt;
      logic [4:0] req;
      logic [2:0] cand;
      logic       found;
      logic       valid_o;
      logic       xfer_o;

      always_comb begin
         for (int i = 0; i < 5; i++) begin
            req[i] = in_valid[i] & in_head[i] & ~owned[i] &
                     (route[3*i +: 3] == 3'(o));
         end
      end

      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            state  <= ST_IDLE;
            owner  <= 3'd0;
            rr_ptr <= 3'd0;
         end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
         end
      end

      // Cyclic search starting at rr_ptr; the pointer moves past the winner.
      always_comb begin
         state_nxt = state;
         owner_nxt = owner;
         rr_nxt    = rr_ptr;
         found     = 1'b0;
         cand      = 3'd0;
         case (state)
            ST_IDLE: begin
               for (int k = 0; k < 5; k++) begin
                  cand = wrap5(4'(rr_ptr) + 4'(k));
                  if (!found && req[cand]) begin
                     found     = 1'b1;
                     owner_nxt = cand;
                  end
               end
               if (found) begin
                  state_nxt = ST_LOCKED;
                  rr_nxt    = wrap5(4'(owner_nxt) + 4'd1);
               end
            end
            ST_LOCKED: begin
               if (xfer_o && in_tail[owner]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      always_comb begin
         valid_o = (state == ST_LOCKED) & in_valid[owner];
         xfer_o  = valid_o & out_ready[o];
      end

      assign out_valid[o]          = valid_o;
      assign xfer[o]               = xfer_o;
      assign lock[o]               = (state == ST_LOCKED);
      assign owner_flat[3*o +: 3]  = owner;
   end

   always_comb begin
      owned   = 5'd0;
      pop_own = 5'd0;
      for (int o = 0; o < 5; o++) begin
         if (lock[o]) owned[owner_flat[3*o +: 3]] = 1'b1;
         if (xfer[o]) pop_own[owner_flat[3*o +: 3]] = 1'b1;
      end
   end

   assign stray = in_valid & ~in_head & ~owned;

   // Gated by reset so the combinational strobes also drop asynchronously.
   assign in_pop    = HRESETn ? (pop_own | stray) : 5'd0;
   assign err_stray = HRESETn & (|stray);
   assign out_sel   = owner_flat;

endmodule
`default_nettype wire

// File: tb/tb_xy_route_ctrl.sv
`default_nettype none
// Bench for xy_route_ctrl at router (1,1): directed vector table, a reset
// mid-packet sequence, then random traffic against a behavioural model.
module tb_xy_route_ctrl;

   localparam int TX = 1;
   localparam int TY = 1;
   localparam logic [4:0] ALL = 5'b11111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  in_valid = '0;
   logic [4:0]  in_head = '0;
   logic [4:0]  in_tail = '0;
   logic [19:0] in_dest = '0;
   logic [4:0]  out_ready = '0;
   logic [4:0]  in_pop;
   logic [4:0]  out_valid;
   logic [14:0] out_sel;
   logic        err_stray;

   always #5 clk = ~clk;

   xy_route_ctrl #(.X(2'd1), .Y(2'd1)) dut (
      .HCLK(clk), .HRESETn(rst_n),
      .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
      .in_dest(in_dest), .in_pop(in_pop), .out_ready(out_ready),
      .out_valid(out_valid), .out_sel(out_sel), .err_stray(err_stray)
   );

   typedef struct {
      logic [4:0]  valid;
      logic [4:0]  head;
      logic [4:0]  tail;
      logic [19:0] dest;
      logic [4:0]  ready;
      logic [4:0]  e_valid;
      logic [4:0]  e_pop;
      logic [14:0] e_sel;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] dl(input int p, input logic [3:0] d);
      logic [19:0] v;
      v = 20'(d);
      return v << (4 * p);
   endfunction

   function automatic logic [14:0] sl(input int l, input int n, input int e, input int s, input int w);
      return 15'(l) | (15'(n) << 3) | (15'(e) << 6) | (15'(s) << 9) | (15'(w) << 12);
   endfunction

   task automatic add(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                      input logic [19:0] d, input logic [4:0] r, input logic [4:0] ev,
                      input logic [4:0] ep, input logic [14:0] es, input logic ee);
      vec_t x;
      x.valid = v; x.head = h; x.tail = t; x.dest = d; x.ready = r;
      x.e_valid = ev; x.e_pop = ep; x.e_sel = es; x.e_err = ee;
      vecs.push_back(x);
   endtask

   // ---------------- behavioural reference model ----------------
   int m_owner[5] = '{-1, -1, -1, -1, -1};
   int m_sel[5]   = '{0, 0, 0, 0, 0};
   int m_ptr[5]   = '{0, 0, 0, 0, 0};

   function automatic int route_of(input logic [3:0] d);
      int dx, dy;
      dx = int'(d[3:2]);
      dy = int'(d[1:0]);
      if (dx > TX) return 2;
      if (dx < TX) return 4;
      if (dy > TY) return 1;
      if (dy < TY) return 3;
      return 0;
   endfunction

   function automatic bit is_busy(input int i);
      for (int o = 0; o < 5; o++) if (m_owner[o] == i) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit busy[5];
      int w, c;
      if (!rst_n) begin
         for (int o = 0; o < 5; o++) begin
            m_owner[o] = -1; m_sel[o] = 0; m_ptr[o] = 0;
         end
      end else begin
         for (int i = 0; i < 5; i++) busy[i] = is_busy(i);
         for (int o = 0; o < 5; o++) begin
            if (m_owner[o] >= 0) begin
               w = m_owner[o];
               if (in_valid[w] && out_ready[o] && in_tail[w]) m_owner[o] = -1;
            end else begin
               for (int k = 0; k < 5; k++) begin
                  c = (m_ptr[o] + k) % 5;
                  if (in_valid[c] && in_head[c] && !busy[c] &&
                      route_of(in_dest[4*c +: 4]) == o) begin
                     m_owner[o] = c; m_sel[o] = c; m_ptr[o] = (c + 1) % 5;
                     break;
                  end
               end
            end
         end
      end
   end

   task automatic model_expect(output logic [4:0] ev, output logic [4:0] ep,
                               output logic [14:0] es, output logic ee);
      ev = '0; ep = '0; ee = 1'b0;
      es = sl(m_sel[0], m_sel[1], m_sel[2], m_sel[3], m_sel[4]);
      for (int o = 0; o < 5; o++) begin
         if (m_owner[o] >= 0 && in_valid[m_owner[o]]) begin
            ev[o] = 1'b1;
            if (out_ready[o]) ep[m_owner[o]] = 1'b1;
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (in_valid[i] && !in_head[i] && !is_busy(i)) begin
            ep[i] = 1'b1; ee = 1'b1;
         end
      end
   endtask

   function automatic logic [4:0] rbits(input int pct);
      logic [4:0] b;
      for (int i = 0; i < 5; i++) b[i] = ($urandom_range(99) < pct);
      return b;
   endfunction

   initial begin
      logic [19:0] d1, d2, d3, d4;
      logic [4:0]  ev, ep;
      logic [14:0] es;
      logic        ee;

      d1 = dl(0, 4'b1001);
      d2 = dl(1, 4'b0101) | dl(3, 4'b0101) | dl(4, 4'b0101);
      d3 = dl(2, 4'b0010) | dl(1, 4'b0000);
      d4 = dl(0, 4'b1001) | dl(1, 4'b0100);

      // L single-flit head to E
      add(5'b00001, 5'b00001, 5'b00001, d1, ALL, 5'b00000, 5'b00000, sl(0,0,0,0,0), 0);
      add(5'b00001, 5'b00001, 5'b00001, d1, ALL, 5'b00100, 5'b00001, sl(0,0,0,0,0), 0);
      add(5'b00000, 5'b00000, 5'b00000, '0, ALL, 5'b00000, 5'b00000, sl(0,0,0,0,0), 0);
      // N, S, W contend for Local, two flits each
      add(5'b11010, 5'b11010, 5'b00000, d2, ALL, 5'b00000, 5'b00000, sl(0,0,0,0,0), 0);
      add(5'b11010, 5'b11010, 5'b00000, d2, ALL, 5'b00001, 5'b00010, sl(1,0,0,0,0), 0);
      add(5'b11010, 5'b11000, 5'b00010, d2, ALL, 5'b00001, 5'b00010, sl(1,0,0,0,0), 0);
      add(5'b11000, 5'b11000, 5'b00000, d2, ALL, 5'b00000, 5'b00000, sl(1,0,0,0,0), 0);
      add(5'b11000, 5'b11000, 5'b00000, d2, ALL, 5'b00001, 5'b01000, sl(3,0,0,0,0), 0);
      add(5'b11000, 5'b10000, 5'b01000, d2, ALL, 5'b00001, 5'b01000, sl(3,0,0,0,0), 0);
      add(5'b10000, 5'b10000, 5'b00000, d2, ALL, 5'b00000, 5'b00000, sl(3,0,0,0,0), 0);
      add(5'b10000, 5'b10000, 5'b00000, d2, ALL, 5'b00001, 5'b10000, sl(4,0,0,0,0), 0);
      add(5'b10000, 5'b00000, 5'b10000, d2, ALL, 5'b00001, 5'b10000, sl(4,0,0,0,0), 0);
      add(5'b00000, 5'b00000, 5'b00000, '0, ALL, 5'b00000, 5'b00000, sl(4,0,0,0,0), 0);
      // 4-flit E->W packet with toggling ready; N waits for W
      add(5'b00100, 5'b00100, 5'b00000, d3, ALL,      5'b00000, 5'b00000, sl(4,0,0,0,0), 0);
      add(5'b00110, 5'b00110, 5'b00010, d3, ALL,      5'b10000, 5'b00100, sl(4,0,0,0,2), 0);
      add(5'b00110, 5'b00010, 5'b00010, d3, 5'b01111, 5'b10000, 5'b00000, sl(4,0,0,0,2), 0);
      add(5'b00110, 5'b00010, 5'b00010, d3, ALL,      5'b10000, 5'b00100, sl(4,0,0,0,2), 0);
      add(5'b00110, 5'b00010, 5'b00010, d3, 5'b01111, 5'b10000, 5'b00000, sl(4,0,0,0,2), 0);
      add(5'b00110, 5'b00010, 5'b00010, d3, ALL,      5'b10000, 5'b00100, sl(4,0,0,0,2), 0);
      add(5'b00110, 5'b00010, 5'b00110, d3, 5'b01111, 5'b10000, 5'b00000, sl(4,0,0,0,2), 0);
      add(5'b00110, 5'b00010, 5'b00110, d3, ALL,      5'b10000, 5'b00100, sl(4,0,0,0,2), 0);
      add(5'b00010, 5'b00010, 5'b00010, d3, ALL,      5'b00000, 5'b00000, sl(4,0,0,0,2), 0);
      add(5'b00010, 5'b00010, 5'b00010, d3, ALL,      5'b10000, 5'b00010, sl(4,0,0,0,1), 0);
      add(5'b00000, 5'b00000, 5'b00000, '0, ALL,      5'b00000, 5'b00000, sl(4,0,0,0,1), 0);
      // concurrent L->E and N->S
      add(5'b00011, 5'b00011, 5'b00011, d4, ALL, 5'b00000, 5'b00000, sl(4,0,0,0,1), 0);
      add(5'b00011, 5'b00011, 5'b00011, d4, ALL, 5'b01100, 5'b00011, sl(4,0,0,1,1), 0);
      add(5'b00000, 5'b00000, 5'b00000, '0, ALL, 5'b00000, 5'b00000, sl(4,0,0,1,1), 0);
      // stray body flit at idle S
      add(5'b01000, 5'b00000, 5'b00000, '0, ALL, 5'b00000, 5'b01000, sl(4,0,0,1,1), 1);
      add(5'b00000, 5'b00000, 5'b00000, '0, ALL, 5'b00000, 5'b00000, sl(4,0,0,1,1), 0);

      // reset state, with a stray-looking flit present
      in_valid = 5'b01000; out_ready = ALL;
      repeat (2) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_pop", 32'(in_pop), 32'd0);
      chk("reset out_sel", 32'(out_sel), 32'd0);
      chk("reset err_stray", 32'(err_stray), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = '0;

      for (int v = 0; v < vecs.size(); v++) begin
         in_valid = vecs[v].valid; in_head = vecs[v].head; in_tail = vecs[v].tail;
         in_dest = vecs[v].dest; out_ready = vecs[v].ready;
         @(negedge clk);
         chk($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(vecs[v].e_valid));
         chk($sformatf("vec%0d in_pop", v), 32'(in_pop), 32'(vecs[v].e_pop));
         chk($sformatf("vec%0d out_sel", v), 32'(out_sel), 32'(vecs[v].e_sel));
         chk($sformatf("vec%0d err_stray", v), 32'(err_stray), 32'(vecs[v].e_err));
         @(posedge clk); #1;
      end

      // reset mid-packet, then leftover body/tail flits are strays
      in_valid = 5'b00001; in_head = 5'b00001; in_tail = 5'b00000;
      in_dest = d1; out_ready = ALL;
      @(negedge clk);
      chk("rst6 pre-grant out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst6 head out_valid", 32'(out_valid), 32'b00100);
      chk("rst6 head in_pop", 32'(in_pop), 32'b00001);
      @(posedge clk); #1;
      in_head = 5'b00000;
      #2;
      chk("rst6 body out_valid", 32'(out_valid), 32'b00100);
      rst_n = 1'b0;
      #1;
      chk("rst6 async out_valid", 32'(out_valid), 32'd0);
      chk("rst6 async in_pop", 32'(in_pop), 32'd0);
      chk("rst6 async out_sel", 32'(out_sel), 32'd0);
      chk("rst6 async err_stray", 32'(err_stray), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst6 stray body in_pop", 32'(in_pop), 32'b00001);
      chk("rst6 stray body err", 32'(err_stray), 32'd1);
      chk("rst6 stray body out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_tail = 5'b00001;
      @(negedge clk);
      chk("rst6 stray tail in_pop", 32'(in_pop), 32'b00001);
      chk("rst6 stray tail err", 32'(err_stray), 32'd1);
      chk("rst6 stray tail out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // random traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         in_valid  = rbits(70);
         in_head   = rbits(40);
         in_tail   = rbits(35);
         in_dest   = 20'($urandom);
         out_ready = rbits(70);
         @(negedge clk);
         model_expect(ev, ep, es, ee);
         chk($sformatf("rand%0d out_valid", n), 32'(out_valid), 32'(ev));
         chk($sformatf("rand%0d in_pop", n), 32'(in_pop), 32'(ep));
         chk($sformatf("rand%0d out_sel", n), 32'(out_sel), 32'(es));
         chk($sformatf("rand%0d err_stray", n), 32'(err_stray), 32'(ee));
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
